// File: rtl/atm_pkg.sv
// Shared types and constants for the ATM session controller and its helpers.
package atm_pkg;

    typedef enum logic [2:0] {
        StIdle  = 3'd0,
        StPin   = 3'd1,
        StMenu  = 3'd2,
        StBal   = 3'd3,
        StCheck = 3'd4,
        StWdraw = 3'd5,
        StDisp  = 3'd6,
        StEject = 3'd7
    } atm_state_e;

    localparam logic [1:0] SEL_BAL  = 2'b00;
    localparam logic [1:0] SEL_WD   = 2'b01;
    localparam logic [1:0] SEL_EXIT = 2'b10;

    // States in which the customer is expected to act; the idle timer runs here.
    function automatic logic timed_state(atm_state_e s);
        return s inside {StPin, StCheck, StMenu, StBal, StWdraw};
    endfunction

endpackage

// File: rtl/atm_idle_timer.sv
// Saturating inactivity counter; expire is high while running with the count at limit.
module atm_idle_timer #(
    parameter int unsigned TW = 10
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          run,
    input  logic          clear,
    input  logic [TW-1:0] limit,
    output logic          expire
);

    logic [TW-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clear) begin
            cnt_d = '0;
        end else if (run && (cnt_q != limit)) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign expire = run && (cnt_q == limit);

endmodule

// File: rtl/atm_session_ctrl.sv
// ATM session sequencer: card/PIN/menu flow, retry counting, idle timeout and
// the dispenser request/acknowledge handshake.
module atm_session_ctrl
    import atm_pkg::*;
#(
    parameter int unsigned MAX_TRIES   = 3,
    parameter int unsigned TIMEOUT_CYC = 1024,
    parameter int unsigned TW          = 10
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       card_in,
    input  logic       b,
    input  logic       e,
    input  logic       o2,
    input  logic       o1,
    input  logic       pin_done,
    input  logic       v,
    input  logic       funds_ok,
    input  logic       disp_ack,
    output logic [2:0] state,
    output logic       pin_chk,
    output logic       disp_req,
    output logic       show_bal,
    output logic       eject_card,
    output logic       retain,
    output logic       err,
    output logic       timeout
);

    localparam int unsigned    AW      = $clog2(MAX_TRIES + 1);
    localparam logic [AW-1:0]  MAX_CNT = AW'(MAX_TRIES);
    localparam logic [TW-1:0]  LIMIT   = TW'(TIMEOUT_CYC - 1);

    atm_state_e    state_q, state_d;
    logic [AW-1:0] tries_q, tries_d;
    logic          pin_chk_q, pin_chk_d, retain_q, retain_d;
    logic          err_q, err_d, timeout_q, timeout_d;
    logic          accepted, expire, tmo, timer_clear;

    atm_idle_timer #(
        .TW (TW)
    ) u_idle_timer (
        .clk    (clk),
        .rst_n  (rst_n),
        .run    (timed_state(state_q)),
        .clear  (timer_clear),
        .limit  (LIMIT),
        .expire (expire)
    );

    always_comb begin
        state_d   = state_q;
        tries_d   = tries_q;
        pin_chk_d = 1'b0;
        retain_d  = 1'b0;
        err_d     = 1'b0;
        timeout_d = 1'b0;
        accepted  = 1'b0;
        tmo       = expire && !b && !e;

        unique case (state_q)
            StIdle: begin
                if (card_in) begin
                    state_d = StPin;
                    tries_d = '0;
                end
            end
            StPin: begin
                if (b) begin
                    state_d  = StEject;
                    accepted = 1'b1;
                end else if (e) begin
                    state_d   = StCheck;
                    pin_chk_d = 1'b1;
                    accepted  = 1'b1;
                end else if (tmo) begin
                    state_d   = StEject;
                    timeout_d = 1'b1;
                end
            end
            StCheck: begin
                if (pin_done) begin
                    if (v) begin
                        state_d = StMenu;
                        tries_d = '0;
                    end else begin
                        tries_d = tries_q + 1'b1;
                        if (tries_d == MAX_CNT) begin
                            state_d  = StIdle;
                            retain_d = 1'b1;
                        end else begin
                            state_d = StPin;
                            err_d   = 1'b1;
                        end
                    end
                end else if (tmo) begin
                    state_d   = StEject;
                    timeout_d = 1'b1;
                end
            end
            StMenu: begin
                if (b) begin
                    state_d  = StEject;
                    accepted = 1'b1;
                end else if (e) begin
                    accepted = 1'b1;
                    case ({o2, o1})
                        SEL_BAL:  state_d = StBal;
                        SEL_WD:   state_d = StWdraw;
                        SEL_EXIT: state_d = StEject;
                        default:  err_d   = 1'b1;
                    endcase
                end else if (tmo) begin
                    state_d   = StEject;
                    timeout_d = 1'b1;
                end
            end
            StBal: begin
                if (b || e) begin
                    state_d  = StMenu;
                    accepted = 1'b1;
                end else if (tmo) begin
                    state_d   = StEject;
                    timeout_d = 1'b1;
                end
            end
            StWdraw: begin
                if (b) begin
                    state_d  = StMenu;
                    accepted = 1'b1;
                end else if (e) begin
                    accepted = 1'b1;
                    if (funds_ok) begin
                        state_d = StDisp;
                    end else begin
                        state_d = StMenu;
                        err_d   = 1'b1;
                    end
                end else if (tmo) begin
                    state_d   = StEject;
                    timeout_d = 1'b1;
                end
            end
            StDisp: begin
                if (disp_ack) state_d = StEject;
            end
            StEject: begin
                if (!card_in) state_d = StIdle;
            end
        endcase

        // A yanked card overrides whatever the current screen decided.
        if (timed_state(state_q) && !card_in) begin
            state_d   = StIdle;
            tries_d   = tries_q;
            pin_chk_d = 1'b0;
            retain_d  = 1'b0;
            timeout_d = 1'b0;
            err_d     = 1'b1;
            accepted  = 1'b0;
        end

        timer_clear = (state_d != state_q) || accepted;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= StIdle;
            tries_q   <= '0;
            pin_chk_q <= 1'b0;
            retain_q  <= 1'b0;
            err_q     <= 1'b0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            tries_q   <= tries_d;
            pin_chk_q <= pin_chk_d;
            retain_q  <= retain_d;
            err_q     <= err_d;
            timeout_q <= timeout_d;
        end
    end

    assign state      = state_q;
    assign pin_chk    = pin_chk_q;
    assign retain     = retain_q;
    assign err        = err_q;
    assign timeout    = timeout_q;
    assign disp_req   = (state_q == StDisp);
    assign show_bal   = (state_q == StBal);
    assign eject_card = (state_q == StEject);

endmodule

// File: tb/tb_atm_session_ctrl.sv
// Directed scenarios plus randomized sessions, checked cycle by cycle against a
// behavioural model of the session rules.
module tb_atm_session_ctrl;

    localparam int unsigned MAX_TRIES   = 3;
    localparam int unsigned TIMEOUT_CYC = 16;
    localparam int unsigned TW          = 5;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic card_in = 1'b0, b = 1'b0, e = 1'b0, o2 = 1'b0, o1 = 1'b0;
    logic pin_done = 1'b0, v = 1'b0, funds_ok = 1'b0, disp_ack = 1'b0;
    logic [2:0] state;
    logic pin_chk, disp_req, show_bal, eject_card, retain, err, timeout;

    int n_checks = 0;
    int n_pass = 0;

    // Model: state code, wrong-PIN count, idle cycles, pulses due this cycle.
    int m_state = 0, m_tries = 0, m_idle = 0;
    bit m_pc = 0, m_rt = 0, m_er = 0, m_to = 0;

    atm_session_ctrl #(
        .MAX_TRIES   (MAX_TRIES),
        .TIMEOUT_CYC (TIMEOUT_CYC),
        .TW          (TW)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .card_in    (card_in),
        .b          (b),
        .e          (e),
        .o2         (o2),
        .o1         (o1),
        .pin_done   (pin_done),
        .v          (v),
        .funds_ok   (funds_ok),
        .disp_ack   (disp_ack),
        .state      (state),
        .pin_chk    (pin_chk),
        .disp_req   (disp_req),
        .show_bal   (show_bal),
        .eject_card (eject_card),
        .retain     (retain),
        .err        (err),
        .timeout    (timeout)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, obs, exp, $time);
    endtask

    function automatic void model_reset();
        m_state = 0; m_tries = 0; m_idle = 0;
        m_pc = 0; m_rt = 0; m_er = 0; m_to = 0;
    endfunction

    function automatic void model_step();
        int ns = m_state;
        bit act = 0;
        bit in_session = (m_state >= 1 && m_state <= 5);
        bit expired = in_session && (m_idle >= TIMEOUT_CYC - 1) && !b && !e;
        m_pc = 0; m_rt = 0; m_er = 0; m_to = 0;
        if (in_session && !card_in) begin
            ns = 0; m_er = 1;
        end else begin
            case (m_state)
                0: if (card_in) begin ns = 1; m_tries = 0; end
                1: if (b) begin ns = 7; act = 1; end
                   else if (e) begin ns = 4; m_pc = 1; act = 1; end
                   else if (expired) begin ns = 7; m_to = 1; end
                4: if (pin_done && v) begin ns = 2; m_tries = 0; end
                   else if (pin_done) begin
                       m_tries++;
                       if (m_tries == MAX_TRIES) begin ns = 0; m_rt = 1; end
                       else begin ns = 1; m_er = 1; end
                   end else if (expired) begin ns = 7; m_to = 1; end
                2: if (b) begin ns = 7; act = 1; end
                   else if (e) begin
                       act = 1;
                       if (!o2 && !o1) ns = 3;
                       else if (!o2 && o1) ns = 5;
                       else if (o2 && !o1) ns = 7;
                       else m_er = 1;
                   end else if (expired) begin ns = 7; m_to = 1; end
                3: if (b || e) begin ns = 2; act = 1; end
                   else if (expired) begin ns = 7; m_to = 1; end
                5: if (b) begin ns = 2; act = 1; end
                   else if (e) begin act = 1; ns = funds_ok ? 6 : 2; m_er = !funds_ok; end
                   else if (expired) begin ns = 7; m_to = 1; end
                6: if (disp_ack) ns = 7;
                7: if (!card_in) ns = 0;
                default: ns = 0;
            endcase
        end
        if (ns != m_state || act) m_idle = 0;
        else if (in_session && m_idle < TIMEOUT_CYC - 1) m_idle++;
        m_state = ns;
    endfunction

    task automatic tick();
        logic [6:0] exp_outs;
        model_step();
        @(posedge clk);
        #1;
        exp_outs = {m_pc, m_state == 6, m_state == 3, m_state == 7, m_rt, m_er, m_to};
        check_eq("state", state, m_state);
        check_eq("outputs", {pin_chk, disp_req, show_bal, eject_card, retain, err, timeout},
                 exp_outs);
        b = 0; e = 0; pin_done = 0; disp_ack = 0;
    endtask

    task automatic go_menu();
        card_in = 1; tick();
        e = 1; tick();
        pin_done = 1; v = 1; tick();
        v = 0;
    endtask

    task automatic go_disp();
        go_menu();
        e = 1; o2 = 0; o1 = 1; tick();
        e = 1; funds_ok = 1; tick();
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #1;
        check_eq("reset_state", state, 0);
        check_eq("reset_outs", {pin_chk, disp_req, show_bal, eject_card, retain, err, timeout}, 0);
        rst_n = 1;
        model_reset();

        // Happy path through a dispense
        go_disp();
        check_eq("happy_disp_req", disp_req, 1);
        tick(); tick();
        disp_ack = 1; tick();
        check_eq("happy_eject_state", state, 7);
        check_eq("happy_eject_card", eject_card, 1);
        card_in = 0; tick();
        check_eq("happy_idle", state, 0);

        // Wrong PIN retries
        card_in = 1; tick();
        for (int i = 1; i <= 3; i++) begin
            e = 1; tick();
            pin_done = 1; v = 0; tick();
            if (i < 3) begin
                check_eq("retry_err", err, 1);
                check_eq("retry_state", state, 1);
            end else begin
                check_eq("retry_retain", retain, 1);
                check_eq("retry_idle", state, 0);
                check_eq("retry_no_eject", eject_card, 0);
            end
        end
        card_in = 0; tick();

        // Inactivity timeout in MENU
        go_menu();
        repeat (TIMEOUT_CYC - 1) tick();
        check_eq("to_not_yet", state, 2);
        tick();
        check_eq("to_pulse", timeout, 1);
        check_eq("to_state", state, 7);
        card_in = 0; tick();

        go_menu();
        repeat (10) tick();
        e = 1; o2 = 1; o1 = 1; tick();
        check_eq("sel11_err", err, 1);
        check_eq("sel11_state", state, 2);
        repeat (TIMEOUT_CYC - 1) tick();
        check_eq("to_restart_not_yet", state, 2);
        tick();
        check_eq("to_restart_pulse", timeout, 1);
        card_in = 0; tick();

        // Priority: B over E in PIN; B ignored in DISP
        card_in = 1; tick();
        b = 1; e = 1; tick();
        check_eq("prio_state", state, 7);
        check_eq("prio_no_pinchk", pin_chk, 0);
        card_in = 0; tick();
        go_disp();
        b = 1; tick();
        check_eq("disp_b_state", state, 6);
        check_eq("disp_b_req", disp_req, 1);
        disp_ack = 1; tick();
        card_in = 0; tick();

        // Insufficient funds, then card yanked in MENU
        go_menu();
        e = 1; o2 = 0; o1 = 1; tick();
        e = 1; funds_ok = 0; tick();
        check_eq("nofunds_err", err, 1);
        check_eq("nofunds_state", state, 2);
        card_in = 0; tick();
        check_eq("yank_err", err, 1);
        check_eq("yank_state", state, 0);

        // Reset asserted mid-dispense
        go_disp();
        #3 rst_n = 0;
        #1;
        check_eq("rst_disp_req", disp_req, 0);
        check_eq("rst_disp_state", state, 0);
        model_reset();
        @(posedge clk);
        #1 rst_n = 1;
        card_in = 1; tick();
        check_eq("rst_rearm", state, 1);
        card_in = 0; tick();

        // Randomized sessions, alternating busy and quiet phases
        for (int blk = 0; blk < 60; blk++) begin
            bit quiet = ($urandom_range(0, 2) == 0);
            for (int c = 0; c < 50; c++) begin
                int sp = quiet ? 64 : 6;
                b        = ($urandom_range(0, sp - 1) == 0);
                e        = ($urandom_range(0, sp - 1) == 0);
                o2       = $urandom_range(0, 1);
                o1       = $urandom_range(0, 1);
                pin_done = ($urandom_range(0, 3) == 0);
                v        = $urandom_range(0, 1);
                funds_ok = $urandom_range(0, 1);
                disp_ack = ($urandom_range(0, 4) == 0);
                if (m_state == 0) card_in = ($urandom_range(0, 3) == 0);
                else if (m_state == 7) card_in = ($urandom_range(0, 2) != 0);
                else card_in = ($urandom_range(0, 49) != 0);
                tick();
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
